// File: rtl/bisc_pkg.sv
// Shared types, defaults and the trailing-zero selector for the BISC PE array.
package bisc_pkg;

    localparam int DEFAULT_BIN_LEN     = 8;
    localparam int DEFAULT_BIN_WIDTH   = $clog2(DEFAULT_BIN_LEN);
    localparam int DEFAULT_OUT_BIN_LEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic       zero_sel;
        logic [7:0] sel;
    } sel_t;

    // Selector = bin_len-1-tz(t); t==0 has no set bit and selects nothing.
    function automatic sel_t tz_select(input logic [31:0] t, input int unsigned bin_len);
        sel_t r;
        int   tz;
        logic found;
        tz    = 0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!found && t[i]) begin
                tz    = i;
                found = 1'b1;
            end
        end
        r.zero_sel = !found;
        r.sel      = found ? 8'(int'(bin_len) - 1 - tz) : 8'd0;
        return r;
    endfunction

endpackage

// File: rtl/bisc_pe_lane.sv
// One lane: latched weight, bit-select mux and wrapping up/down accumulator.
module bisc_pe_lane #(
    parameter int BIN_LEN     = 8,
    parameter int BIN_WIDTH   = $clog2(BIN_LEN),
    parameter int OUT_BIN_LEN = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   en,
    input  logic [BIN_LEN-1:0]     weight_in,
    input  logic                   sub_in,
    input  logic [OUT_BIN_LEN-1:0] init_val,
    input  logic [BIN_WIDTH-1:0]   sel,
    input  logic                   zero_sel,
    output logic [OUT_BIN_LEN-1:0] acc
);

    logic [BIN_LEN-1:0]     weight_q, weight_d;
    logic                   sub_q, sub_d;
    logic [OUT_BIN_LEN-1:0] acc_q, acc_d;
    logic                   bit_s;

    // Select the weight bit, then load, accumulate or hold.
    always_comb begin
        weight_d = weight_q;
        sub_d    = sub_q;
        acc_d    = acc_q;
        bit_s    = zero_sel ? 1'b0 : weight_q[sel];
        if (load) begin
            weight_d = weight_in;
            sub_d    = sub_in;
            acc_d    = init_val;
        end else if (en) begin
            if (sub_q) acc_d = acc_q - {{(OUT_BIN_LEN-1){1'b0}}, bit_s};
            else       acc_d = acc_q + {{(OUT_BIN_LEN-1){1'b0}}, bit_s};
        end
    end

    // Lane registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            weight_q <= '0;
            sub_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            weight_q <= weight_d;
            sub_q    <= sub_d;
            acc_q    <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/bisc_pe_array.sv
// Multi-lane bit-serial stochastic MAC: FSM, stream index t, x latch, handshakes.
//   state | meaning
//   IDLE  | waiting for a job, in_ready high
//   RUN   | one accumulate step per non-held edge
//   DONE  | results valid until out_ready
module bisc_pe_array
    import bisc_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int BIN_LEN     = DEFAULT_BIN_LEN,
    parameter int BIN_WIDTH   = $clog2(BIN_LEN),
    parameter int OUT_BIN_LEN = DEFAULT_OUT_BIN_LEN
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_LEN-1:0]           x_val,
    input  logic [LANES*BIN_LEN-1:0]     weights,
    input  logic [LANES*OUT_BIN_LEN-1:0] init_vals,
    input  logic [LANES-1:0]             sub_mask,
    input  logic                         hold,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OUT_BIN_LEN-1:0] out_vals
);

    state_e               state_q, state_d;
    logic [BIN_LEN-1:0]   t_q, t_d;
    logic [BIN_LEN-1:0]   x_q, x_d;
    logic                 accept;
    logic                 run_en;
    sel_t                 sel_s;

    // Next state, counters and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        x_d       = x_q;
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
        accept    = 1'b0;
        run_en    = 1'b0;
        sel_s     = tz_select(32'(t_q), BIN_LEN);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    x_d     = x_val;
                    t_d     = '0;
                    state_d = (x_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!hold) begin
                    run_en = 1'b1;
                    t_d    = t_q + 1'b1;
                    if (t_q == x_q - BIN_LEN'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            x_q     <= x_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bisc_pe_lane #(
            .BIN_LEN     (BIN_LEN),
            .BIN_WIDTH   (BIN_WIDTH),
            .OUT_BIN_LEN (OUT_BIN_LEN)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .load      (accept),
            .en        (run_en),
            .weight_in (weights[i*BIN_LEN +: BIN_LEN]),
            .sub_in    (sub_mask[i]),
            .init_val  (init_vals[i*OUT_BIN_LEN +: OUT_BIN_LEN]),
            .sel       (sel_s.sel[BIN_WIDTH-1:0]),
            .zero_sel  (sel_s.zero_sel),
            .acc       (out_vals[i*OUT_BIN_LEN +: OUT_BIN_LEN])
        );
    end

endmodule

// File: tb/tb_bisc_pe_array.sv
// Directed self-checking bench for bisc_pe_array.
module tb_bisc_pe_array;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_val;
    logic [31:0] weights;
    logic [63:0] init_vals;
    logic [3:0]  sub_mask;
    logic        hold;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vals;

    // Narrow-accumulator instance for wrap checks.
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_x_val;
    logic [15:0] s_weights;
    logic [15:0] s_init_vals;
    logic [1:0]  s_sub_mask;
    logic        s_hold;
    logic        s_busy;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_vals;

    int checks = 0;
    int errors = 0;

    bisc_pe_array #(.LANES(4), .BIN_LEN(8), .BIN_WIDTH(3), .OUT_BIN_LEN(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_val(x_val), .weights(weights), .init_vals(init_vals), .sub_mask(sub_mask),
        .hold(hold), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_vals(out_vals)
    );

    bisc_pe_array #(.LANES(2), .BIN_LEN(8), .BIN_WIDTH(3), .OUT_BIN_LEN(8)) dut_s (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x_val(s_x_val), .weights(s_weights), .init_vals(s_init_vals), .sub_mask(s_sub_mask),
        .hold(s_hold), .busy(s_busy), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_vals(s_out_vals)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Accept one job, scramble inputs afterwards, optionally hold, count edges to out_valid.
    task automatic do_job(input logic [7:0] x, input logic [31:0] w, input logic [63:0] iv,
                          input logic [3:0] m, input int hold_at, input int hold_len,
                          output int lat);
        x_val = x; weights = w; init_vals = iv; sub_mask = m; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        lat       = 1;
        x_val     = 8'($urandom);
        weights   = $urandom;
        init_vals = {$urandom, $urandom};
        sub_mask  = 4'($urandom);
        while (!out_valid && lat < 2000) begin
            hold = (lat >= hold_at && lat < hold_at + hold_len);
            @(posedge clock); #1;
            lat++;
        end
        hold = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b ov=%b exp 1 0 0", in_ready, busy, out_valid);
        end
        checks++;
        if (out_vals !== 64'd0) begin
            errors++;
            $display("FAIL reset_vals got %h exp 0", out_vals);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int lat;
        do_job(8'd255, {8'h00, 8'hFF, 8'h01, 8'h80}, 64'd0, 4'b0000, 9999, 0, lat);
        checks++;
        if (lat !== 256) begin
            errors++;
            $display("FAIL basic_latency got %0d exp 256", lat);
        end
        checks++;
        if (out_vals !== {16'd0, 16'd254, 16'd1, 16'd127}) begin
            errors++;
            $display("FAIL basic_vals got %h exp %h", out_vals, {16'd0, 16'd254, 16'd1, 16'd127});
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_ctrl got rdy=%b busy=%b exp 0 0", in_ready, busy);
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release got rdy=%b ov=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_sub();
        int lat;
        do_job(8'd128, {8'h40, 8'h03, 8'h80, 8'h80}, {16'd5, 16'd0, 16'd1000, 16'd1000},
               4'b1001, 9999, 0, lat);
        checks++;
        if (lat !== 129) begin
            errors++;
            $display("FAIL sub_latency got %0d exp 129", lat);
        end
        checks++;
        if (out_vals !== {16'd65509, 16'd1, 16'd1064, 16'd936}) begin
            errors++;
            $display("FAIL sub_vals got %h exp %h", out_vals, {16'd65509, 16'd1, 16'd1064, 16'd936});
        end
        release_out();
    endtask

    task automatic test_zero_x();
        int lat;
        int bad;
        do_job(8'd0, 32'hFFFF_FFFF, {4{16'h1234}}, 4'b1111, 9999, 0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL zero_latency got %0d exp 1", lat);
        end
        checks++;
        if (out_vals !== {4{16'h1234}}) begin
            errors++;
            $display("FAIL zero_vals got %h exp %h", out_vals, {4{16'h1234}});
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            hold = i[0];
            @(posedge clock); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        hold = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL zero_stall got %0d bad cycles exp 0", bad);
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_release got rdy=%b ov=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_hold();
        int lat;
        do_job(8'd255, {4{8'hFF}}, 64'd0, 4'b0000, 100, 5, lat);
        checks++;
        if (lat !== 261) begin
            errors++;
            $display("FAIL hold_latency got %0d exp 261", lat);
        end
        checks++;
        if (out_vals !== {4{16'd254}}) begin
            errors++;
            $display("FAIL hold_vals got %h exp %h", out_vals, {4{16'd254}});
        end
        release_out();
        // Hold asserted on what would be the final RUN edge.
        do_job(8'd255, {4{8'hFF}}, 64'd0, 4'b0000, 255, 5, lat);
        checks++;
        if (lat !== 261) begin
            errors++;
            $display("FAIL hold_last_latency got %0d exp 261", lat);
        end
        checks++;
        if (out_vals !== {4{16'd254}}) begin
            errors++;
            $display("FAIL hold_last_vals got %h exp %h", out_vals, {4{16'd254}});
        end
        release_out();
    endtask

    task automatic test_wrap();
        int lat;
        s_x_val = 8'd255; s_weights = 16'hFFFF; s_init_vals = {8'h02, 8'hF0};
        s_sub_mask = 2'b10; s_in_valid = 1'b1;
        @(posedge clock); #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 2000) begin
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (lat !== 256) begin
            errors++;
            $display("FAIL wrap_latency got %0d exp 256", lat);
        end
        checks++;
        if (s_out_vals !== {8'h04, 8'hEE}) begin
            errors++;
            $display("FAIL wrap_vals got %h exp %h", s_out_vals, {8'h04, 8'hEE});
        end
        s_out_ready = 1'b1;
        @(posedge clock); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        x_val = 8'd200; weights = {4{8'hFF}}; init_vals = {4{16'd7}}; sub_mask = 4'b0000;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || out_vals === 64'd0) begin
            errors++;
            $display("FAIL mid_running got busy=%b vals=%h exp busy 1 nonzero", busy, out_vals);
        end
        reset = 1'b0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (out_vals !== 64'd0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got vals=%h rdy=%b busy=%b ov=%b exp 0 1 0 0",
                     out_vals, in_ready, busy, out_valid);
        end
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_vals !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset_wins got rdy=%b busy=%b vals=%h exp 1 0 0", in_ready, busy, out_vals);
        end
        do_job(8'd255, {8'h00, 8'hFF, 8'h01, 8'h80}, 64'd0, 4'b0000, 9999, 0, lat);
        checks++;
        if (lat !== 256 || out_vals !== {16'd0, 16'd254, 16'd1, 16'd127}) begin
            errors++;
            $display("FAIL mid_rerun got lat=%0d vals=%h exp 256 %h", lat, out_vals,
                     {16'd0, 16'd254, 16'd1, 16'd127});
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_job(8'd3, {8'h01, 8'h40, 8'h80, 8'hC0}, 64'd0, 4'b0000, 9999, 0, lat);
        checks++;
        if (lat !== 4 || out_vals !== {16'd0, 16'd1, 16'd1, 16'd2}) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d vals=%h exp 4 %h", lat, out_vals,
                     {16'd0, 16'd1, 16'd1, 16'd2});
        end
        x_val = 8'd3; weights = {8'h01, 8'h40, 8'h80, 8'hC0}; init_vals = {4{16'd10}};
        sub_mask = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vals !== {16'd0, 16'd1, 16'd1, 16'd2}) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b ov=%b vals=%h exp 1 0 unchanged", in_ready, out_valid, out_vals);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b rdy=%b exp 1 0", busy, in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 2000) begin
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || out_vals !== {16'd10, 16'd11, 16'd11, 16'd12}) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d vals=%h exp 4 %h", lat, out_vals,
                     {16'd10, 16'd11, 16'd11, 16'd12});
        end
        release_out();
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; x_val = '0; weights = '0; init_vals = '0;
        sub_mask = '0; hold = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_x_val = '0; s_weights = '0; s_init_vals = '0;
        s_sub_mask = '0; s_hold = 1'b0; s_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_sub();
        test_zero_x();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bisc_pe_array.md
# bisc_pe_array

Parametrised multi-lane bit-serial stochastic MAC array for the BISC matrix-vector datapath. One activation `x` is applied as a stream of `x` cycles to `LANES` weights in parallel. Each cycle, every lane adds or subtracts one weight bit, chosen by a shared trailing-zero sequencer. Each lane therefore accumulates ≈ w·x/2^BIN_LEN onto its init value. It generalises the single processing element with:

- an internal sequencer and FSM
- a valid/ready handshake on both sides
- per-lane subtract mode
- a global hold

## Interface
Parameters:
- LANES, 4, number of parallel weight lanes
- BIN_LEN, 8, weight and activation width
- BIN_WIDTH, $clog2(BIN_LEN), selector width
- OUT_BIN_LEN, 16, accumulator width per lane

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; asserted (0) means reset on the next rising edge
- in_valid  in  1  job offered
- in_ready  out  1  array idle, can accept a job
- x_val  in  BIN_LEN  activation, equal to the number of accumulate cycles
- weights  in  LANES*BIN_LEN  lane i at [i*BIN_LEN +: BIN_LEN], unsigned
- init_vals  in  LANES*OUT_BIN_LEN  per-lane accumulator preload
- sub_mask  in  LANES  bit i = 1: lane i decrements instead of increments
- hold  in  1  freezes accumulation and the sequencer while high
- busy  out  1  high in RUN
- out_valid  out  1  results available
- out_ready  in  1  consumer takes results
- out_vals  out  LANES*OUT_BIN_LEN  lane accumulators, lane i at [i*OUT_BIN_LEN +: OUT_BIN_LEN]

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: latch weights and sub_mask, load acc[i]<=init_vals[i], and set t<=0.
  - The next state is RUN if x_val≠0, else DONE.
  - x_val is latched as x.
- **RUN:** each edge with hold=0:
  - acc[i] <= acc[i] ± bit[i]; the sign comes from sub_mask[i].
  - t <= t+1.
  - If t==x-1, go to DONE.
- **DONE:**
  - out_valid=1; out_vals is stable.
  - On out_ready, go to IDLE.
- **Sequencer:**
  - t is a BIN_LEN-bit index.
  - zero_select when t==0, giving bit=0.
  - Otherwise selector = BIN_LEN-1-tz(t), where tz is the trailing-zero count, and bit[i] = weights[i][selector].
  - Over t=0..2^BIN_LEN-1, bit j is selected exactly 2^j times.
- **Arithmetic:** acc wraps modulo 2^OUT_BIN_LEN in both directions, with no saturation and no flags.
- **Hold:**
  - In RUN, hold freezes t, acc and state.
  - In IDLE and DONE, hold has no effect.
- **Handshake:**
  - Inputs are sampled only on the in_valid&&in_ready edge; changes outside that edge are ignored.
  - No new job is accepted until the out handshake completes. in_ready is 0 in RUN and DONE.
- **Reset** (any state, including mid-RUN):
  - state=IDLE, t=0, acc=0, latched regs=0.
  - in_ready=1, busy=0, out_valid=0, out_vals=0.

## Timing
- Latency: out_valid rises x+1 non-held edges after the accept edge. This counts the accept edge and includes x=0, which gives 1 edge.
- out_vals is registered, with no combinational path from inputs to outputs.
- in_ready is combinational from state only.
- Simultaneous reset and in_valid: reset wins.
- Simultaneous hold and the final RUN edge: the transition is deferred until hold is low.
- Back-to-back operation:
  - The DONE→IDLE edge is one cycle.
  - The earliest next accept is the edge after it.
  - Throughput is one job per x+2 cycles minimum.

## Structure
- Package bisc_pkg holds:
  - the state enum {IDLE, RUN, DONE}
  - function `tz_select(t)`, which returns the selector and zero_select
  - existing macros BIN_LEN, BIN_WIDTH and OUT_BIN_LEN as defaults
- Sub-module bisc_pe_lane, instantiated LANES times via generate. It contains:
  - the weight register
  - the bit-select mux
  - the up/down accumulator with load
- The top level holds the FSM, t, x and the handshake.

## Test plan
- LANES=4 with weights {0x80,0x01,0xFF,0x00}, x=255, init=0, sub_mask=0 → out_vals {127,1,254,0}, out_valid 256 edges after accept.
- weight 0x80, x=128, init=1000, sub_mask=1 on that lane → lane = 936; a parallel lane with weight 0x80, sub_mask=0, init=1000 → 1064.
- x=0, init=0x1234 → out_vals=0x1234 one edge after accept; a held out_ready=0 keeps out_valid=1 and in_ready=0 for 10 cycles; release → IDLE next edge.
- x=255, weight 0xFF, hold pulsed for 5 cycles mid-RUN → same results as with no hold, latency +5.
- OUT_BIN_LEN=8, init=0xF0, weight 0xFF, x=255 → 0xEE (wrap); with sub_mask=1, init=0x02 → 0x04 (wrap on underflow).
- reset=0 for one edge during RUN at t=50 → all outputs 0, in_ready=1; a new job then completes with correct values.
